midi_note_parser: RTL and testbench
===================================

// Module: midi_note_parser
// PURPOSE
//  Monophonic MIDI byte-stream parser sitting directly upstream of the DDS oscillator.
//  Consumes bytes from the UART receiver and decodes Note On/Off with running status.
//  Drives the oscillator's note index and one-cycle change_note strobe, plus gate and
//  velocity for the downstream envelope.
// PARAMETERS
//  CHANNEL     0    MIDI channel 0..15 accepted; used only when MIDI_CHANNEL_FILTER_EN is defined
//  RESET_NOTE  69   note index presented on `note` out of reset (A4)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  rx_valid     in   1  rx_data holds a new byte this cycle (single-cycle strobe per byte)
//  rx_data      in   8  received MIDI byte
//  note         out  7  current note index, registered, held between updates
//  change_note  out  1  one-cycle strobe; note is valid in the same cycle
//  velocity     out  7  velocity of the last accepted Note On
//  gate         out  1  high while the current note is sounding
//  rx_error     out  1  one-cycle strobe: data byte received with no running status
// BEHAVIOUR
//  Reset (async assert, sync release): note=RESET_NOTE, velocity=0, gate=0,
//   change_note=0, rx_error=0, state=NO_STATUS, running status cleared.
//  Byte classes: status = bit7 set; data = bit7 clear.
//  Real-time bytes 0xF8..0xFF are ignored entirely: no state, status or output change.
//  System common/exclusive 0xF0..0xF7: clear running status; go to NO_STATUS.
//   Following data bytes are discarded without raising rx_error.
//  Channel status 0x80..0xEF: latch as running status and go to WAIT_D1.
//   A status byte always aborts any partial message.
//  FSM states:
//   NO_STATUS: data byte -> rx_error pulse, except after 0xF0..0xF7 (silently discarded).
//   WAIT_D1: data byte -> latch d1.
//    2-byte types (0x8,0x9,0xA,0xB,0xE) -> WAIT_D2.
//    1-byte types (0xC,0xD) -> consumed, stay in WAIT_D1 (running status).
//   WAIT_D2: data byte -> execute message; return to WAIT_D1 (running status retained).
//  Execute, registered one cycle after the rx_valid beat of the final data byte:
//   Note On, vel>0: note<=d1, velocity<=d2, gate<=1, change_note=1.
//   Note On, vel=0, or Note Off: if d1==note then gate<=0; otherwise no effect.
//    change_note stays 0 and note/velocity are unchanged.
//   0xA/0xB/0xE: consumed, no output effect.
//  Last-note priority: a new Note On while gate=1 retargets note and pulses change_note.
//   gate stays 1.
//  Latency: rx_valid of d2 at cycle N -> change_note/note/gate updated at N+1.
//  Back-to-back rx_valid on consecutive cycles is supported at full rate.
//  Reset mid-message discards the partial message and running status.
// CONFIGURATION
//  MIDI_CHANNEL_FILTER_EN defined: channel status bytes whose low nibble != CHANNEL
//   are latched as running status but marked foreign.
//   Their messages are consumed with no output effect.
//  Not defined: omni mode; all 16 channels are accepted and CHANNEL is unused.
// STRUCTURE
//  midi_pkg: status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, ...),
//   state enum {NO_STATUS, WAIT_D1, WAIT_D2}, and a msg_len(type) function returning 1 or 2.
//  One sub-module, midi_status_decode (combinational): rx_data -> is_status, is_realtime,
//   is_syscommon, msg_type, msg_channel.
//  The FSM, running-status registers and output registers live in midi_note_parser.
// TESTING
//  1 Bytes 90 3C 64 -> next cycle: change_note=1 for 1 cycle, note=60, velocity=100, gate=1.
//  2 Then 3E 50 with no status (running status) -> note=62, velocity=80, change_note pulse, gate=1.
//    Then 80 3C 00 -> gate stays 1; then 90 3E 00 -> gate=0, note=62.
//  3 Bytes 90 3C, then F8, then 64 -> identical result to test 1 (real-time byte transparent).
//  4 Bytes C0 05 07 (program change with running status), then 40 after reset
//    -> no output change; after reset, lone 40 -> rx_error pulse.
//  5 Bytes 90 3C, then F0 7E F7, then 40 -> no note change, no rx_error; state NO_STATUS.
//  6 Filter on, CHANNEL=0: 91 3C 64 -> no effect; 90 3C 64 -> note=60.
//    Assert rst between 90 and 3C -> outputs return to reset values and the partial message is dropped.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg
//   Shared definitions for the MIDI note parser:
//     - channel-voice status nibble constants
//     - parser state enum
//     - msg_len(): number of data bytes carried by a channel-voice message type
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_AT    = 4'hA;
    localparam logic [3:0] CTRL_CHG   = 4'hB;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_AT    = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;

    typedef enum logic [1:0] {
        NO_STATUS = 2'd0,
        WAIT_D1   = 2'd1,
        WAIT_D2   = 2'd2
    } parse_state_t;

    // Program change and channel aftertouch carry one data byte; every other
    // channel-voice message carries two.
    function automatic logic [1:0] msg_len(input logic [3:0] msg_type);
        if (msg_type == PROG_CHG || msg_type == CHAN_AT) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/midi_status_decode.sv
// midi_status_decode
//   Purely combinational classification of one received MIDI byte.
// Ports:
//   rx_data      in   8  received byte
//   is_status    out  1  bit 7 set
//   is_realtime  out  1  0xF8..0xFF
//   is_syscommon out  1  0xF0..0xF7 (system common / exclusive)
//   msg_type     out  4  high nibble (message type for channel status bytes)
//   msg_channel  out  4  low nibble (channel for channel status bytes)
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_status,
    output logic       is_realtime,
    output logic       is_syscommon,
    output logic [3:0] msg_type,
    output logic [3:0] msg_channel
);

    assign is_status    = rx_data[7];
    assign is_realtime  = (rx_data[7:3] == 5'b11111);
    assign is_syscommon = (rx_data[7:3] == 5'b11110);
    assign msg_type     = rx_data[7:4];
    assign msg_channel  = rx_data[3:0];

endmodule

// File: rtl/midi_note_parser.sv
// midi_note_parser
//   Monophonic MIDI byte-stream parser feeding the DDS oscillator (note index and
//   change_note strobe) and the envelope (gate, velocity). Decodes Note On / Note Off
//   with running status; all other channel messages are parsed and discarded.
// Optional build macro:
//   MIDI_CHANNEL_FILTER_EN  only channel CHANNEL is acted upon; other channels are
//                           tracked as running status but their messages are ignored.
//                           When undefined, all 16 channels are accepted (omni).
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   rx_valid     in   1  rx_data holds a new byte this cycle
//   rx_data      in   8  received MIDI byte
//   note         out  7  current note index (held between updates)
//   change_note  out  1  one-cycle strobe, note valid in the same cycle
//   velocity     out  7  velocity of last accepted Note On
//   gate         out  1  high while the current note sounds
//   rx_error     out  1  one-cycle strobe: data byte with no running status
module midi_note_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter logic [6:0] RESET_NOTE = 7'd69
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [6:0] note,
    output logic       change_note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       rx_error
);

    logic       is_status;
    logic       is_realtime;
    logic       is_syscommon;
    logic [3:0] msg_type;
    logic [3:0] msg_channel;
    logic       foreign_status;

    midi_status_decode u_decode (
        .rx_data      (rx_data),
        .is_status    (is_status),
        .is_realtime  (is_realtime),
        .is_syscommon (is_syscommon),
        .msg_type     (msg_type),
        .msg_channel  (msg_channel)
    );

`ifdef MIDI_CHANNEL_FILTER_EN
    assign foreign_status = (msg_channel != CHANNEL);
`else
    // Omni: every channel is ours. The comparison is kept (and masked) so the
    // channel decode stays connected in both builds.
    assign foreign_status = (msg_channel != CHANNEL) & 1'b0;
`endif

    parse_state_t state_reg, state_next;
    logic [3:0]   run_type_reg, run_type_next;
    logic         foreign_reg, foreign_next;
    // Set after 0xF0..0xF7 so that trailing SysEx / system common data bytes
    // are dropped quietly instead of flagged as orphans.
    logic         sys_discard_reg, sys_discard_next;
    logic [6:0]   d1_reg, d1_next;
    logic [6:0]   note_reg, note_next;
    logic [6:0]   velocity_reg, velocity_next;
    logic         gate_reg, gate_next;
    logic         change_note_reg, change_note_next;
    logic         rx_error_reg, rx_error_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= NO_STATUS;
            run_type_reg    <= 4'd0;
            foreign_reg     <= 1'b0;
            sys_discard_reg <= 1'b0;
            d1_reg          <= 7'd0;
            note_reg        <= RESET_NOTE;
            velocity_reg    <= 7'd0;
            gate_reg        <= 1'b0;
            change_note_reg <= 1'b0;
            rx_error_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_type_reg    <= run_type_next;
            foreign_reg     <= foreign_next;
            sys_discard_reg <= sys_discard_next;
            d1_reg          <= d1_next;
            note_reg        <= note_next;
            velocity_reg    <= velocity_next;
            gate_reg        <= gate_next;
            change_note_reg <= change_note_next;
            rx_error_reg    <= rx_error_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        run_type_next    = run_type_reg;
        foreign_next     = foreign_reg;
        sys_discard_next = sys_discard_reg;
        d1_next          = d1_reg;
        note_next        = note_reg;
        velocity_next    = velocity_reg;
        gate_next        = gate_reg;
        change_note_next = 1'b0;
        rx_error_next    = 1'b0;

        // Real-time bytes may appear anywhere, even mid-message, and are invisible.
        if (rx_valid && !is_realtime) begin
            if (is_status) begin
                if (is_syscommon) begin
                    state_next       = NO_STATUS;
                    run_type_next    = 4'd0;
                    foreign_next     = 1'b0;
                    sys_discard_next = 1'b1;
                end else begin
                    state_next       = WAIT_D1;
                    run_type_next    = msg_type;
                    foreign_next     = foreign_status;
                    sys_discard_next = 1'b0;
                end
            end else begin
                unique case (state_reg)
                    NO_STATUS: begin
                        if (!sys_discard_reg) begin
                            rx_error_next = 1'b1;
                        end
                    end
                    WAIT_D1: begin
                        d1_next = rx_data[6:0];
                        // One-byte messages complete here and stay in WAIT_D1
                        // for the next running-status message.
                        if (msg_len(run_type_reg) == 2'd2) begin
                            state_next = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        state_next = WAIT_D1;
                        if (!foreign_reg) begin
                            if (run_type_reg == NOTE_ON && rx_data[6:0] != 7'd0) begin
                                note_next        = d1_reg;
                                velocity_next    = rx_data[6:0];
                                gate_next        = 1'b1;
                                change_note_next = 1'b1;
                            end else if ((run_type_reg == NOTE_ON || run_type_reg == NOTE_OFF)
                                         && d1_reg == note_reg) begin
                                // Release only the note that is sounding; releasing
                                // an older, superseded note must not cut the current one.
                                gate_next = 1'b0;
                            end
                        end
                    end
                    default: state_next = NO_STATUS;
                endcase
            end
        end
    end

    assign note        = note_reg;
    assign change_note = change_note_reg;
    assign velocity    = velocity_reg;
    assign gate        = gate_reg;
    assign rx_error    = rx_error_reg;

endmodule

// File: tb/tb_midi_note_parser.sv
// tb_midi_note_parser
//   Drives MIDI byte sequences into midi_note_parser. Each byte pushes the expected
//   output state (one cycle later) onto a scoreboard queue; a monitor pops and compares.
//   Cycles without a byte must show no strobes.
module tb_midi_note_parser;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [6:0] note;
    logic       change_note;
    logic [6:0] velocity;
    logic       gate;
    logic       rx_error;

    midi_note_parser #(
        .CHANNEL    (4'd0),
        .RESET_NOTE (7'd69)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .note        (note),
        .change_note (change_note),
        .velocity    (velocity),
        .gate        (gate),
        .rx_error    (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] byte_in;
        logic       chg;
        logic [6:0] note;
        logic [6:0] vel;
        logic       gate;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks_cnt   = 0;
    int   failures_cnt = 0;

    task automatic check_value(input string tag, input int obs, input int expv);
        checks_cnt++;
        if (obs !== expv) begin
            failures_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one byte for one cycle and record the expected outputs after it.
    task automatic send(input logic [7:0] b, input logic chg, input logic [6:0] n,
                        input logic [6:0] v, input logic g, input logic e);
        exp_t x;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        x.byte_in = b; x.chg = chg; x.note = n; x.vel = v; x.gate = g; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic do_reset();
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("rst_note", note, 69);
        check_value("rst_vel", velocity, 0);
        check_value("rst_gate", gate, 0);
        check_value("rst_chg", change_note, 0);
        check_value("rst_err", rx_error, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: outputs are registered, so the result of a byte sampled at a
    // rising edge is checked at the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst !== 1'b0) continue;
            if (rx_valid === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check_value("queue_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_value($sformatf("chg@%02h", e.byte_in), change_note, e.chg);
                    check_value($sformatf("note@%02h", e.byte_in), note, e.note);
                    check_value($sformatf("vel@%02h", e.byte_in), velocity, e.vel);
                    check_value($sformatf("gate@%02h", e.byte_in), gate, e.gate);
                    check_value($sformatf("err@%02h", e.byte_in), rx_error, e.err);
                    $display("byte %02h: chg=%0d note=%0d vel=%0d gate=%0d err=%0d",
                             e.byte_in, change_note, note, velocity, gate, rx_error);
                end
            end else begin
                @(negedge clk);
                check_value("idle_chg", change_note, 0);
                check_value("idle_err", rx_error, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        do_reset();

        // 1: Note On 60 vel 100
        send(8'h90, 0, 69, 0, 0, 0);
        send(8'h3C, 0, 69, 0, 0, 0);
        send(8'h64, 1, 60, 100, 1, 0);
        idle(2);
        // 2: running status retarget, then releases
        send(8'h3E, 0, 60, 100, 1, 0);
        send(8'h50, 1, 62, 80, 1, 0);
        send(8'h80, 0, 62, 80, 1, 0);
        send(8'h3C, 0, 62, 80, 1, 0);
        send(8'h00, 0, 62, 80, 1, 0);   // release of a non-current note
        send(8'h90, 0, 62, 80, 1, 0);
        send(8'h3E, 0, 62, 80, 1, 0);
        send(8'h00, 0, 62, 80, 0, 0);   // Note On vel 0 releases current note
        idle(2);

        // 3: real-time byte inside a message
        do_reset();
        send(8'h90, 0, 69, 0, 0, 0);
        send(8'h3C, 0, 69, 0, 0, 0);
        send(8'hF8, 0, 69, 0, 0, 0);
        send(8'h64, 1, 60, 100, 1, 0);
        idle(2);

        // 4: program change with running status, then orphan data after reset
        send(8'hC0, 0, 60, 100, 1, 0);
        send(8'h05, 0, 60, 100, 1, 0);
        send(8'h07, 0, 60, 100, 1, 0);
        send(8'h40, 0, 60, 100, 1, 0);
        do_reset();
        send(8'h40, 0, 69, 0, 0, 1);
        idle(2);

        // 5: SysEx aborts the partial note and its data is silently discarded
        send(8'h90, 0, 69, 0, 0, 0);
        send(8'h3C, 0, 69, 0, 0, 0);
        send(8'hF0, 0, 69, 0, 0, 0);
        send(8'h7E, 0, 69, 0, 0, 0);
        send(8'hF7, 0, 69, 0, 0, 0);
        send(8'h40, 0, 69, 0, 0, 0);
        send(8'h64, 0, 69, 0, 0, 0);
        idle(2);

        // 6: other channel (filtered or omni), then channel 0
`ifdef MIDI_CHANNEL_FILTER_EN
        send(8'h91, 0, 69, 0, 0, 0);
        send(8'h3C, 0, 69, 0, 0, 0);
        send(8'h64, 0, 69, 0, 0, 0);
`else
        send(8'h91, 0, 69, 0, 0, 0);
        send(8'h3C, 0, 69, 0, 0, 0);
        send(8'h64, 1, 60, 100, 1, 0);
`endif
        send(8'h90, 0, 69 - ((69 - 60) * `ifdef MIDI_CHANNEL_FILTER_EN 0 `else 1 `endif), `ifdef MIDI_CHANNEL_FILTER_EN 0 `else 100 `endif, `ifdef MIDI_CHANNEL_FILTER_EN 0 `else 1 `endif, 0);
        send(8'h3C, 0, 69 - ((69 - 60) * `ifdef MIDI_CHANNEL_FILTER_EN 0 `else 1 `endif), `ifdef MIDI_CHANNEL_FILTER_EN 0 `else 100 `endif, `ifdef MIDI_CHANNEL_FILTER_EN 0 `else 1 `endif, 0);
        send(8'h64, 1, 60, 100, 1, 0);
        send(8'h91, 0, 60, 100, 1, 0);
        send(8'h3C, 0, 60, 100, 1, 0);
        send(8'h00, 0, 60, 100, `ifdef MIDI_CHANNEL_FILTER_EN 1 `else 0 `endif, 0);
        idle(2);

        // Reset between status and data drops the partial message and running status.
        send(8'h90, 0, 60, 100, `ifdef MIDI_CHANNEL_FILTER_EN 1 `else 0 `endif, 0);
        do_reset();
        send(8'h3C, 0, 69, 0, 0, 1);
        send(8'h64, 0, 69, 0, 0, 1);
        idle(3);

        check_value("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
